// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the LEGv8 pipeline hazard controller: FSM encoding,
// the zero-register index and the bundle of per-stage register controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_ERR_DRAIN = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic memwb_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } stage_ctrl_t;

  // Free-running pipeline: every register loads, nothing squashed.
  localparam stage_ctrl_t CTRL_FLOW = '{
    pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1, exmem_write: 1'b1,
    memwb_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0,
    idex_bubble: 1'b0, memwb_bubble: 1'b0
  };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources of the
// instruction in IF/ID. Purely combinational so the forwarding unit can share it.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rn,
  input  logic [4:0] ifid_rm,
  input  logic       ifid_uses_rm,
  output logic       load_use
);

  logic rn_match;
  logic rm_match;

  assign rn_match = (idex_rd == ifid_rn);
  assign rm_match = ifid_uses_rm && (idex_rd == ifid_rm);

  // XZR always reads as zero, so a load targeting it never produces a value to wait for.
  assign load_use = idex_memread && (idex_rd != XZR_IDX) && (rn_match || rm_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: load-use stalls, taken-branch flushes resolved
// in MEM, data-memory waits with timeout, and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic             ifid_uses_rm,
  input  logic             exmem_branch_taken,
  input  logic             exmem_memaccess,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_VAL = TCNT_W'(MEM_TIMEOUT);

  ctrl_state_e       state_q;
  logic [TCNT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_hold;
  logic              branch_flush;
  stage_ctrl_t       ctrl;

  hazard_detect u_hazard_detect (
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_rn      (ifid_rn),
    .ifid_rm      (ifid_rm),
    .ifid_uses_rm (ifid_uses_rm),
    .load_use     (load_use)
  );

  // Data-memory handshake: an access is pending whenever exmem_memaccess is
  // high, and it completes on any cycle dmem_ready is high; EX/MEM holds until then.
  assign mem_hold = !dmem_ready &&
                    ((state_q == ST_MEM_WAIT) || ((state_q == ST_RUN) && exmem_memaccess));

  always_comb begin
    ctrl         = CTRL_FLOW;
    branch_flush = 1'b0;
    if (RESET) begin
      ctrl = '{default: 1'b1};
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_write  = 1'b0;
      ctrl.idex_write  = 1'b0;
      ctrl.exmem_write = 1'b0;
      ctrl.memwb_write = 1'b0;
    end else if (state_q == ST_ERR_DRAIN) begin
      ctrl.exmem_flush  = 1'b1;
      ctrl.memwb_bubble = 1'b1;
    end else if (mem_hold) begin
      ctrl.pc_write     = 1'b0;
      ctrl.ifid_write   = 1'b0;
      ctrl.idex_write   = 1'b0;
      ctrl.exmem_write  = 1'b0;
      ctrl.memwb_bubble = 1'b1;
    end else if (exmem_branch_taken) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      branch_flush     = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_write  = 1'b0;
      ctrl.idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      wait_cnt     <= '0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_hold) begin
            state_q  <= ST_MEM_WAIT;
            wait_cnt <= TCNT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_hold) begin
            state_q  <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT_VAL) begin
            state_q   <= ST_ERR_DRAIN;
            wait_cnt  <= '0;
            mem_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TCNT_W'(1);
          end
        end
        default: begin
          state_q  <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
      if (!ctrl.pc_write && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (branch_flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign idex_write   = ctrl.idex_write;
  assign exmem_write  = ctrl.exmem_write;
  assign memwb_write  = ctrl.memwb_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_flush  = ctrl.exmem_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, every
// cycle compared against a rule-level model of the pipeline controls.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 8;
  localparam int MAXC    = (1 << CW) - 1;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          idex_memread, ifid_uses_rm, exmem_branch_taken, exmem_memaccess, dmem_ready;
  logic [4:0]    idex_rd, ifid_rn, ifid_rm;
  logic          pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic          ifid_flush, idex_flush, exmem_flush, idex_bubble, memwb_bubble, mem_error;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending-access flag with its wait length, drain flag, sticky error, counts.
  bit m_waiting, m_drain, m_err;
  int m_wait_n, m_stalls, m_flushes;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rn(ifid_rn), .ifid_rm(ifid_rm),
    .ifid_uses_rm(ifid_uses_rm), .exmem_branch_taken(exmem_branch_taken),
    .exmem_memaccess(exmem_memaccess), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .state(state)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, check, then advance the model past the rising edge.
  task automatic step(input string ph, input bit rst, input bit mr, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm, input bit urm,
                      input bit br, input bit ma, input bit rdy);
    bit          hz, hold;
    logic [9:0]  e;
    int          e_state;
    @(negedge CLOCK);
    RESET = rst; idex_memread = mr; idex_rd = rd; ifid_rn = rn; ifid_rm = rm;
    ifid_uses_rm = urm; exmem_branch_taken = br; exmem_memaccess = ma; dmem_ready = rdy;
    #1;
    hz   = mr && (rd != 5'd31) && ((rd == rn) || (urm && (rd == rm)));
    hold = !rdy && (m_waiting || ma) && !m_drain;
    // {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f, idex_b, memwb_b}
    if (rst)          e = 10'b00000_111_11;
    else if (m_drain) e = 10'b11111_001_01;
    else if (hold)    e = 10'b00001_000_01;
    else if (br)      e = 10'b11111_111_00;
    else if (hz)      e = 10'b00111_000_10;
    else              e = 10'b11111_000_00;
    e_state = m_drain ? 2 : (m_waiting ? 1 : 0);
    check({ph, ":ctrl"}, 32'({pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                              ifid_flush, idex_flush, exmem_flush, idex_bubble, memwb_bubble}),
          32'(e));
    check({ph, ":state"}, 32'(state), 32'(e_state));
    check({ph, ":mem_error"}, 32'(mem_error), 32'(m_err));
    check({ph, ":stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
    check({ph, ":flush_count"}, 32'(flush_count), 32'(m_flushes));
    if (rst) begin
      m_waiting = 0; m_drain = 0; m_err = 0; m_wait_n = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!e[9] && m_stalls < MAXC) m_stalls++;
      if (!m_drain && !hold && br && m_flushes < MAXC) m_flushes++;
      if (m_drain) m_drain = 0;
      else if (hold) begin
        if (!m_waiting) begin
          m_waiting = 1; m_wait_n = 1;
        end else if (m_wait_n == TIMEOUT) begin
          m_waiting = 0; m_drain = 1; m_err = 1;
        end else m_wait_n++;
      end else m_waiting = 0;
    end
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1);
  endtask

  initial begin
    RESET = 1'b1; idex_memread = 0; idex_rd = 0; ifid_rn = 0; ifid_rm = 0;
    ifid_uses_rm = 0; exmem_branch_taken = 0; exmem_memaccess = 0; dmem_ready = 1;

    step("reset", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    step("reset", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    idle("idle", 2);

    // Load-use on rn, then the load has moved on and the condition clears.
    step("load_use", 0, 1, 5'd5, 5'd5, 5'd9, 0, 0, 0, 1);
    idle("load_use_after", 1);
    step("load_use_rm", 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 1);
    step("rm_unused", 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 1);
    step("xzr", 0, 1, 5'd31, 5'd31, 5'd31, 1, 0, 0, 1);
    step("branch_load_use", 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 1);
    step("access_ready", 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 1);

    // Memory wait: ready low three cycles, high on the fourth.
    for (int i = 0; i < 3; i++) step("mem_wait", 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0);
    step("mem_ready", 0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 1, 1);
    idle("post_wait", 1);

    // Timeout: ready never arrives.
    for (int i = 0; i < TIMEOUT + 1; i++) step("timeout", 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0);
    step("err_drain", 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0);
    idle("after_err", 3);

    // Reset in the middle of a wait.
    for (int i = 0; i < 2; i++) step("pre_reset_wait", 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0);
    step("reset_mid_wait", 1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 1, 0);
    step("reset_mid_wait", 1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 1, 0);
    idle("post_reset", 2);

    // Random traffic in blocks with varying memory latency; counters reach saturation.
    for (int blk = 0; blk < 60; blk++) begin
      int rdy_pct;
      case ($urandom_range(0, 2))
        0:       rdy_pct = 20;
        1:       rdy_pct = 75;
        default: rdy_pct = 100;
      endcase
      for (int i = 0; i < 64; i++) begin
        bit         rst, mr, urm, br, ma, rdy;
        logic [4:0] rd, rn, rm;
        rst = ($urandom_range(0, 999) == 0);
        mr  = ($urandom_range(0, 1) == 1);
        urm = ($urandom_range(0, 1) == 1);
        br  = ($urandom_range(0, 3) == 0);
        ma  = ($urandom_range(0, 2) == 0);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        rd  = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
        rn  = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
        rm  = 5'($urandom_range(0, 3));
        step("random", rst, mr, rd, rn, rm, urm, br, ma, rdy);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
